freq_meter: RTL and testbench
=============================

# freq_meter

Gated frequency meter that counts rising edges of an asynchronous square-wave input over a fixed window of system-clock cycles and publishes each result in binary and 6-digit BCD. It sits on the measurement side of the lab platform: the selectable test-signal generator drives `sigin`, and the BCD result feeds the seven-segment display driver. Windows run back-to-back without dead time, and BCD conversion runs in parallel with the next window.

## Interface
Parameters:
- `GATE_CYCLES`, default 100000000: window length in `sysclk` cycles (1 s at 100 MHz). Must be ≥ 32.
- `SAT`, default 999999: saturation limit of the edge count. Must be ≤ 999999.

Ports:
- `sysclk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-low reset. One clock; the reset polarity and asynchronous behaviour are fixed.
- `sigin`  in  1  signal under test, asynchronous to `sysclk`.
- `freq`  out  20  binary edge count of the last completed window, saturated at `SAT`.
- `bcd`  out  24  six BCD digits of `freq`; `[23:20]` is the most significant digit.
- `ovf`  out  1  high when the last completed window exceeded `SAT` edges.
- `valid`  out  1  one-cycle pulse when `freq`, `bcd` and `ovf` update.

## Operation
Input synchronizer and edge detection:
- `sigin` passes through two flip-flops (`s1`, `s2`) and then a delay flip-flop (`s3`).
- `edge = s2 & ~s3`. All three flip-flops reset to 0.
- A `sigin` that is high at reset release therefore counts as one rising edge.
- The maximum countable rate is one edge per 2 cycles.

Gate counter `gcnt` (0 to `GATE_CYCLES`-1):
- Increments every cycle and wraps to 0.
- At the edge where `gcnt == GATE_CYCLES-1` (event E0):
  - The snapshot takes the count including any edge in that cycle, plus the window overflow flag.
  - `ecnt` clears, to 0 or to 1 if `edge` is high in the first cycle of the next window.
  - The window overflow flag clears.
- An edge in the cycle where `gcnt == GATE_CYCLES-1` belongs to the ending window. An edge in the cycle where `gcnt == 0` belongs to the new window.

Edge counter `ecnt` (20-bit):
- Increments on `edge`.
- If `edge` arrives while `ecnt == SAT`, `ecnt` holds its value and the window overflow flag sets.

Converter FSM, states IDLE, SHIFT, DONE:
- IDLE: at E0, load the snapshot into the shift register and go to SHIFT with `bitcnt = 0`.
- SHIFT: double-dabble, one step per cycle.
  - Add 3 to every BCD nibble ≥ 5, then shift left by one bit, taking the next binary MSB.
  - Run 20 steps; after the 20th, go to DONE.
- DONE: register `freq`, `bcd` and `ovf`, pulse `valid`, and go to IDLE.
- Because `GATE_CYCLES ≥ 32`, the FSM always reaches IDLE before the next E0. No snapshot is lost or overwritten.

Reset:
- Asynchronous. Asserting `rst` at any time, including mid-window or mid-conversion, immediately clears all state and outputs.
- No `valid` pulse is produced for an interrupted window or conversion.

## Timing
- Reset values: `freq = 0`, `bcd = 0`, `ovf = 0`, `valid = 0`, `gcnt = 0`, `ecnt = 0`, FSM in IDLE.
- `sigin` rising edge to counted: 2 to 3 `sysclk` edges, depending on metastability resolution.
- E0 to outputs: `freq`, `bcd` and `ovf` change at the 21st clock edge after E0. `valid` is high for exactly the following cycle.
- Outputs hold between updates.
- The `valid` period is exactly `GATE_CYCLES` cycles.
- The first `valid` after reset release comes `GATE_CYCLES + 21` edges after release.

## Test plan
1. `GATE_CYCLES=100000`, `sigin` synchronous with period 8 (4 high / 4 low), starting low -> every window reports `freq = 12500`, `bcd = 24'h012500`, `ovf = 0`; `valid` pulses are exactly 100000 cycles apart; the first pulse lands at release + 100021.
2. `GATE_CYCLES=1000`, `sigin` held 0 -> `freq = 0`, `bcd = 0`, `ovf = 0`, with a `valid` pulse every 1000 cycles.
3. `GATE_CYCLES=200`, `SAT=50`, `sigin` toggling every cycle (100 edges per window) -> `freq = 50`, `bcd = 24'h000050`, `ovf = 1`. Then switch to period 8 (25 edges per window) -> the next result is `freq = 25`, `ovf = 0`.
4. `GATE_CYCLES=1000`, period-8 input, with `rst` pulsed low at `gcnt = 500` and again during SHIFT -> outputs read 0 immediately with no `valid` pulse; the first `valid` after the final release lands at release + 1021 with `freq = 125`.
5. `GATE_CYCLES=1000`, single `sigin` pulses placed so that `edge` occurs at `gcnt = 999`, and separately at `gcnt = 0` -> the first case is counted in the ending window (`freq = 1`, then 0); the second is counted in the next window.
6. `GATE_CYCLES=1000`, `sigin` high before reset release and never toggled -> the first result is `freq = 1`, all later results are 0.

Source files
------------

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter
// Description : Gated edge counter with back-to-back windows and a
//               double-dabble binary-to-BCD converter for the result.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int SAT         = 999999
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        sigin,
    output logic [19:0] freq,
    output logic [23:0] bcd,
    output logic        ovf,
    output logic        valid
);

    localparam int                    c_GCNT_W    = $clog2(GATE_CYCLES);
    localparam logic [c_GCNT_W-1:0]   c_GCNT_LAST = c_GCNT_W'(GATE_CYCLES - 1);
    localparam logic [19:0]           c_SAT       = 20'(SAT);
    localparam logic [4:0]            c_LAST_STEP = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic [c_GCNT_W-1:0] r_gcnt;
    logic [19:0]         r_ecnt;
    logic                r_wovf;

    state_t              r_state;
    logic [4:0]          r_bitcnt;
    logic [23:0]         r_bcd_sh;
    logic [19:0]         r_bin_sh;
    logic [19:0]         r_snap;
    logic                r_snap_ovf;

    logic                w_edge;
    logic                w_e0;
    logic                w_at_sat;
    logic [19:0]         w_snap_cnt;
    logic                w_snap_ovf;
    logic [23:0]         w_bcd_adj;
    logic [43:0]         w_step;

    assign w_edge   = r_s2 & ~r_s3;
    assign w_e0     = (r_gcnt == c_GCNT_LAST);
    assign w_at_sat = (r_ecnt == c_SAT);

    // The snapshot includes an edge landing in the last cycle of the window.
    assign w_snap_cnt = (w_edge && !w_at_sat) ? r_ecnt + 20'd1 : r_ecnt;
    assign w_snap_ovf = r_wovf | (w_edge & w_at_sat);

    for (genvar i = 0; i < 6; i++) begin : g_nibble
        assign w_bcd_adj[4*i +: 4] = (r_bcd_sh[4*i +: 4] >= 4'd5) ?
                                     r_bcd_sh[4*i +: 4] + 4'd3 : r_bcd_sh[4*i +: 4];
    end

    assign w_step = {w_bcd_adj, r_bin_sh} << 1;

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_gcnt <= '0;
            r_ecnt <= '0;
            r_wovf <= 1'b0;
        end else begin
            r_s1   <= sigin;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_gcnt <= w_e0 ? '0 : r_gcnt + 1'b1;
            if (w_e0) begin
                r_ecnt <= '0;
                r_wovf <= 1'b0;
            end else if (w_edge) begin
                if (w_at_sat) begin
                    r_wovf <= 1'b1;
                end else begin
                    r_ecnt <= r_ecnt + 20'd1;
                end
            end
        end
    end

    // Conversion finishes well inside the next window, so E0 always finds IDLE.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= '0;
            r_bcd_sh   <= '0;
            r_bin_sh   <= '0;
            r_snap     <= '0;
            r_snap_ovf <= 1'b0;
            freq       <= '0;
            bcd        <= '0;
            ovf        <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_e0) begin
                        r_bcd_sh   <= '0;
                        r_bin_sh   <= w_snap_cnt;
                        r_snap     <= w_snap_cnt;
                        r_snap_ovf <= w_snap_ovf;
                        r_bitcnt   <= '0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {r_bcd_sh, r_bin_sh} <= w_step;
                    if (r_bitcnt == c_LAST_STEP) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_bitcnt <= r_bitcnt + 5'd1;
                    end
                end
                ST_DONE: begin
                    freq    <= r_snap;
                    bcd     <= r_bcd_sh;
                    ovf     <= r_snap_ovf;
                    valid   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_meter
// Description : Directed scoreboard bench for freq_meter (short and wide gate).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

    localparam int c_GATE   = 2400;
    localparam int c_SAT    = 600;
    localparam int c_GATE_W = 19998;

    typedef struct packed {
        logic [19:0] f;
        logic        o;
        logic        c;
    } exp_t;

    logic        sysclk;
    logic        rst;
    logic        sigin;
    logic [19:0] freq;
    logic [23:0] bcd;
    logic        ovf;
    logic        valid;

    logic        rst_w;
    logic        sigin_w;
    logic [19:0] freq_w;
    logic [23:0] bcd_w;
    logic        ovf_w;
    logic        valid_w;

    int   total = 0;
    int   bad   = 0;
    int   cyc;
    int   half;
    bit   first;
    int   last_v;
    exp_t sb[$];
    exp_t sbw[$];

    freq_meter #(.GATE_CYCLES(c_GATE), .SAT(c_SAT)) u_dut (
        .sysclk(sysclk), .rst(rst), .sigin(sigin),
        .freq(freq), .bcd(bcd), .ovf(ovf), .valid(valid)
    );

    freq_meter #(.GATE_CYCLES(c_GATE_W)) u_wide (
        .sysclk(sysclk), .rst(rst_w), .sigin(sigin_w),
        .freq(freq_w), .bcd(bcd_w), .ovf(ovf_w), .valid(valid_w)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    always @(posedge sysclk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Periodic stimulus: half > 0 selects a square wave, phase restarted by reset.
    initial begin : gen
        int ph;
        ph = 0;
        forever begin
            @(negedge sysclk);
            if (half != 0) begin
                if (!rst) begin
                    ph    = 0;
                    sigin = 1'b0;
                end else begin
                    sigin = (ph >= half);
                    ph    = (ph + 1) % (2 * half);
                end
            end
        end
    end

    initial begin : gen_w
        int ph;
        ph      = 0;
        sigin_w = 1'b0;
        forever begin
            @(negedge sysclk);
            if (!rst_w) begin
                ph      = 0;
                sigin_w = 1'b0;
            end else begin
                sigin_w = (ph >= 1);
                ph      = (ph + 1) % 2;
            end
        end
    end

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          x;
        x = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int f, input bit o, input bit c);
        exp_t e;
        e.f = 20'(f);
        e.o = o;
        e.c = c;
        sb.push_back(e);
    endtask

    task automatic push_w(input int f);
        exp_t e;
        e.f = 20'(f);
        e.o = 1'b0;
        e.c = 1'b1;
        sbw.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge sysclk);
        #2 rst = 1'b1;
        first  = 1'b1;
        last_v = -1;
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < 100000 && cyc < n; k++) @(negedge sysclk);
    endtask

    task automatic get_result();
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int n = 0; n < 3 * c_GATE && !seen; n++) begin
            @(negedge sysclk);
            if (valid) seen = 1'b1;
        end
        if (!seen) begin
            chk("valid_timeout", 24'(seen), 24'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            chk("sb_underflow", 24'(sb.size()), 24'd1);
        end else begin
            e = sb.pop_front();
            if (e.c) begin
                chk("freq", 24'(freq), 24'(e.f));
                chk("bcd", bcd, to_bcd(int'(e.f)));
                chk("ovf", 24'(ovf), 24'(e.o));
            end
            if (first) chk("first_valid_cycle", 24'(cyc), 24'(c_GATE + 21));
            else if (last_v >= 0) chk("valid_period", 24'(cyc - last_v), 24'(c_GATE));
            last_v = cyc;
            first  = 1'b0;
            @(negedge sysclk);
            chk("valid_width", 24'(valid), 24'd0);
        end
    endtask

    always @(negedge sysclk) begin
        if (valid_w) begin
            if (sbw.size() == 0) begin
                chk("wide_unexpected", 24'(sbw.size()), 24'd1);
            end else begin
                exp_t e;
                e = sbw.pop_front();
                chk("wide_freq", 24'(freq_w), 24'(e.f));
                chk("wide_bcd", bcd_w, to_bcd(int'(e.f)));
                chk("wide_ovf", 24'(ovf_w), 24'(e.o));
            end
        end
    end

    initial begin
        rst    = 1'b0;
        rst_w  = 1'b0;
        sigin  = 1'b0;
        half   = 0;
        first  = 1'b0;
        last_v = -1;
        repeat (3) @(negedge sysclk);
        chk("reset_freq", 24'(freq), 24'd0);
        chk("reset_bcd", bcd, 24'd0);
        chk("reset_ovf", 24'(ovf), 24'd0);
        chk("reset_valid", 24'(valid), 24'd0);

        // High input at release counts once; wide unit sees a steady toggle.
        sigin = 1'b1;
        push_w(9997);
        push_w(9999);
        push_w(9999);
        push(1, 1'b0, 1'b1);
        push(0, 1'b0, 1'b1);
        #2;
        rst    = 1'b1;
        rst_w  = 1'b1;
        first  = 1'b1;
        last_v = -1;
        wait_cyc(c_GATE + 20);
        chk("pre_update_freq", 24'(freq), 24'd0);
        chk("pre_update_valid", 24'(valid), 24'd0);
        get_result();
        get_result();

        // Single edges on either side of the window boundary.
        sigin = 1'b0;
        do_reset();
        push(1, 1'b0, 1'b1);
        push(0, 1'b0, 1'b1);
        push(1, 1'b0, 1'b1);
        push(0, 1'b0, 1'b1);
        wait_cyc(c_GATE - 3);
        sigin = 1'b1;
        @(negedge sysclk);
        sigin = 1'b0;
        get_result();
        wait_cyc(2 * c_GATE - 2);
        sigin = 1'b1;
        @(negedge sysclk);
        sigin = 1'b0;
        get_result();
        get_result();
        get_result();

        // Saturation, exact-limit and several sub-limit rates.
        half = 1;
        push(0, 1'b0, 1'b0); push(600, 1'b1, 1'b1); push(600, 1'b1, 1'b1);
        repeat (3) get_result();
        half = 2;
        push(0, 1'b0, 1'b0); push(600, 1'b0, 1'b1); push(600, 1'b0, 1'b1);
        repeat (3) get_result();
        half = 4;
        push(0, 1'b0, 1'b0); push(300, 1'b0, 1'b1);
        repeat (2) get_result();
        half = 8;
        push(0, 1'b0, 1'b0); push(150, 1'b0, 1'b1);
        repeat (2) get_result();
        half = 5;
        push(0, 1'b0, 1'b0); push(240, 1'b0, 1'b1);
        repeat (2) get_result();
        half = 4;
        push(0, 1'b0, 1'b0); push(300, 1'b0, 1'b1);
        repeat (2) get_result();

        // Reset mid-window, then again mid-conversion.
        repeat (1200) @(negedge sysclk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_freq", 24'(freq), 24'd0);
        chk("midrst_bcd", bcd, 24'd0);
        chk("midrst_valid", 24'(valid), 24'd0);
        repeat (2) @(negedge sysclk);
        #2 rst = 1'b1;
        first  = 1'b1;
        last_v = -1;
        wait_cyc(c_GATE + 5);
        #2 rst = 1'b0;
        #1;
        chk("shiftrst_valid", 24'(valid), 24'd0);
        repeat (2) @(negedge sysclk);
        #2 rst = 1'b1;
        first  = 1'b1;
        last_v = -1;
        push(300, 1'b0, 1'b1);
        get_result();

        for (int k = 0; k < 30000 && sbw.size() != 0; k++) @(negedge sysclk);
        chk("wide_pending", 24'(sbw.size()), 24'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
